// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: write port, scoreboard set port, two read ports.
// The master drives indices, data and enables. The slave (the register file)
// returns the registered read data and the busy flags.
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  logic              LD_REG;
  logic [IDX_W-1:0]  DR;
  logic [DATA_W-1:0] d_bus;
  logic [IDX_W-1:0]  SR1;
  logic [IDX_W-1:0]  SR2;
  logic              SB_SET;
  logic [IDX_W-1:0]  SB_DR;
  logic [DATA_W-1:0] SR1_out;
  logic [DATA_W-1:0] SR2_out;
  logic              SR1_busy;
  logic              SR2_busy;

  modport master (
    output LD_REG, DR, d_bus, SR1, SR2, SB_SET, SB_DR,
    input  SR1_out, SR2_out, SR1_busy, SR2_busy
  );

  modport slave (
    input  LD_REG, DR, d_bus, SR1, SR2, SB_SET, SB_DR,
    output SR1_out, SR2_out, SR1_busy, SR2_busy
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: N x W register file with one write port, two registered read
// ports and a per-register busy scoreboard for RAW stall detection.
// Optional macro REGFILE_BYPASS_EN: the read ports return the post-update
// state of the same cycle (write data and next busy value) rather than the
// pre-update state.
// Indices >= NUM_REGS, and index 0 when ZERO_REG0=1, are never written and
// never marked busy, so they read back as 0 / not busy.
module reg_file_sb #(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 8,
  parameter int IDX_W     = 3,
  parameter int ZERO_REG0 = 0
) (
  input  logic          Clk,
  input  logic          Reset_ah,
  reg_file_sb_if.slave  bus
);

  localparam logic [IDX_W:0] LP_NUM_REGS = (IDX_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic                w_wr_ok;
  logic                w_sb_ok;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [DATA_W-1:0]   w_rd1_data;
  logic [DATA_W-1:0]   w_rd2_data;
  logic                w_rd1_busy;
  logic                w_rd2_busy;

  function automatic logic f_idx_ok(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < LP_NUM_REGS) && !((ZERO_REG0 != 0) && (idx == '0));
  endfunction

  assign w_wr_ok = bus.LD_REG && f_idx_ok(bus.DR);
  assign w_sb_ok = bus.SB_SET && f_idx_ok(bus.SB_DR);

  // Next busy vector: a completed write clears, a new issue sets, set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_wr_ok && (bus.DR == IDX_W'(i)))    w_busy_nxt[i] = 1'b0;
      if (w_sb_ok && (bus.SB_DR == IDX_W'(i))) w_busy_nxt[i] = 1'b1;
    end
  end

  // Read-port muxes; indices with no backing register fall through to 0.
  always_comb begin
    w_rd1_data = '0;
    w_rd2_data = '0;
    w_rd1_busy = 1'b0;
    w_rd2_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.SR1 == IDX_W'(i)) begin
        w_rd1_data = r_regs[i];
`ifdef REGFILE_BYPASS_EN
        w_rd1_busy = w_busy_nxt[i];
`else
        w_rd1_busy = r_busy[i];
`endif
      end
      if (bus.SR2 == IDX_W'(i)) begin
        w_rd2_data = r_regs[i];
`ifdef REGFILE_BYPASS_EN
        w_rd2_busy = w_busy_nxt[i];
`else
        w_rd2_busy = r_busy[i];
`endif
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && (bus.DR == bus.SR1)) w_rd1_data = bus.d_bus;
    if (w_wr_ok && (bus.DR == bus.SR2)) w_rd2_data = bus.d_bus;
`endif
  end

  // Register array, scoreboard and registered read outputs.
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy       <= '0;
      bus.SR1_out  <= '0;
      bus.SR2_out  <= '0;
      bus.SR1_busy <= 1'b0;
      bus.SR2_busy <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_ok && (bus.DR == IDX_W'(i))) r_regs[i] <= bus.d_bus;
      end
      r_busy       <= w_busy_nxt;
      bus.SR1_out  <= w_rd1_data;
      bus.SR2_out  <= w_rd2_data;
      bus.SR1_busy <= w_rd1_busy;
      bus.SR2_busy <= w_rd2_busy;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb. Three instances share one stimulus stream:
//   u_a : 8 regs, R0 writable
//   u_b : 6 regs (indices 6,7 unbacked)
//   u_c : 8 regs, hard-zero R0
// Expected values are hand-computed; REGFILE_BYPASS_EN selects the
// same-cycle expectations.
module tb_reg_file_sb;

  logic        Clk = 1'b0;
  logic        Reset_ah;
  logic        ld, sbset;
  logic [2:0]  dr, sr1, sr2, sbdr;
  logic [15:0] dbus;

  int checks   = 0;
  int failures = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 Clk = ~Clk;

  reg_file_sb_if #(.DATA_W(16), .IDX_W(3)) if_a ();
  reg_file_sb_if #(.DATA_W(16), .IDX_W(3)) if_b ();
  reg_file_sb_if #(.DATA_W(16), .IDX_W(3)) if_c ();

  assign if_a.LD_REG = ld;    assign if_b.LD_REG = ld;    assign if_c.LD_REG = ld;
  assign if_a.DR     = dr;    assign if_b.DR     = dr;    assign if_c.DR     = dr;
  assign if_a.d_bus  = dbus;  assign if_b.d_bus  = dbus;  assign if_c.d_bus  = dbus;
  assign if_a.SR1    = sr1;   assign if_b.SR1    = sr1;   assign if_c.SR1    = sr1;
  assign if_a.SR2    = sr2;   assign if_b.SR2    = sr2;   assign if_c.SR2    = sr2;
  assign if_a.SB_SET = sbset; assign if_b.SB_SET = sbset; assign if_c.SB_SET = sbset;
  assign if_a.SB_DR  = sbdr;  assign if_b.SB_DR  = sbdr;  assign if_c.SB_DR  = sbdr;

  reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .IDX_W(3), .ZERO_REG0(0))
    u_a (.Clk(Clk), .Reset_ah(Reset_ah), .bus(if_a.slave));
  reg_file_sb #(.DATA_W(16), .NUM_REGS(6), .IDX_W(3), .ZERO_REG0(0))
    u_b (.Clk(Clk), .Reset_ah(Reset_ah), .bus(if_b.slave));
  reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .IDX_W(3), .ZERO_REG0(1))
    u_c (.Clk(Clk), .Reset_ah(Reset_ah), .bus(if_c.slave));

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    ld = 1'b0; sbset = 1'b0; Reset_ah = 1'b0;
  endtask

  task automatic test_reset();
    Reset_ah = 1'b1; ld = 1'b0; sbset = 1'b0;
    dr = 3'd0; sr1 = 3'd0; sr2 = 3'd0; sbdr = 3'd0; dbus = 16'h0;
    tick(); tick();
    idle();
    checks++;
    if (if_a.SR1_out !== 16'h0 || if_a.SR2_out !== 16'h0 ||
        if_a.SR1_busy !== 1'b0 || if_a.SR2_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%h/%b/%b exp=0000/0000/0/0",
               if_a.SR1_out, if_a.SR2_out, if_a.SR1_busy, if_a.SR2_busy);
    end
    ld = 1'b1; dr = 3'd3; dbus = 16'hBEEF;
    tick();
    ld = 1'b0; sr1 = 3'd3;
    tick();
    checks++;
    if (if_a.SR1_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL pre_reset_r3 got=%h exp=BEEF", if_a.SR1_out);
    end
    Reset_ah = 1'b1;
    tick();
    Reset_ah = 1'b0;
    tick();
    checks++;
    if (if_a.SR1_out !== 16'h0 || if_a.SR1_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_r3 got=%h/%b exp=0000/0", if_a.SR1_out, if_a.SR1_busy);
    end
  endtask

  // Reset asserted together with a write and a busy set on R1: reset wins,
  // and a busy bit set earlier (a stall in progress) is cleared too.
  task automatic test_reset_override();
    sbset = 1'b1; sbdr = 3'd2;
    tick();
    Reset_ah = 1'b1; sbset = 1'b1; sbdr = 3'd1; ld = 1'b1; dr = 3'd1; dbus = 16'h5555;
    tick();
    idle(); sr1 = 3'd1; sr2 = 3'd2;
    tick();
    checks++;
    if (if_a.SR1_out !== 16'h0 || if_a.SR1_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_override_r1 got=%h/%b exp=0000/0", if_a.SR1_out, if_a.SR1_busy);
    end
    checks++;
    if (if_a.SR2_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_stall_r2 got=%b exp=0", if_a.SR2_busy);
    end
  endtask

  task automatic test_write_read();
    ld = 1'b1; dr = 3'd5; dbus = 16'h1234;
    tick();
    ld = 1'b0; sr1 = 3'd5; sr2 = 3'd5;
    tick();
    checks++;
    if (if_a.SR1_out !== 16'h1234 || if_a.SR2_out !== 16'h1234) begin
      failures++;
      $display("FAIL write_read_r5 got=%h/%h exp=1234/1234", if_a.SR1_out, if_a.SR2_out);
    end
    checks++;
    if (if_b.SR1_out !== 16'h1234 || if_b.SR2_out !== 16'h1234) begin
      failures++;
      $display("FAIL write_read_r5_n6 got=%h/%h exp=1234/1234", if_b.SR1_out, if_b.SR2_out);
    end
  endtask

  task automatic test_same_cycle_raw();
    logic [15:0] exp_v;
    ld = 1'b1; dr = 3'd2; dbus = 16'h0001;
    tick();
    ld = 1'b1; dr = 3'd2; dbus = 16'h00FF; sr1 = 3'd2;
    tick();
    exp_v = BYP ? 16'h00FF : 16'h0001;
    checks++;
    if (if_a.SR1_out !== exp_v) begin
      failures++;
      $display("FAIL raw_same_cycle got=%h exp=%h", if_a.SR1_out, exp_v);
    end
    ld = 1'b0;
    tick();
    checks++;
    if (if_a.SR1_out !== 16'h00FF) begin
      failures++;
      $display("FAIL raw_next_cycle got=%h exp=00FF", if_a.SR1_out);
    end
  endtask

  task automatic test_scoreboard();
    logic exp_b;
    sbset = 1'b1; sbdr = 3'd4; sr2 = 3'd4;
    tick();
    exp_b = BYP;
    checks++;
    if (if_a.SR2_busy !== exp_b) begin
      failures++;
      $display("FAIL sb_set_same_cycle got=%b exp=%b", if_a.SR2_busy, exp_b);
    end
    sbset = 1'b0;
    tick();
    checks++;
    if (if_a.SR2_busy !== 1'b1) begin
      failures++;
      $display("FAIL sb_busy_r4 got=%b exp=1", if_a.SR2_busy);
    end
    ld = 1'b1; dr = 3'd4; dbus = 16'h4444;
    tick();
    exp_b = !BYP;
    checks++;
    if (if_a.SR2_busy !== exp_b) begin
      failures++;
      $display("FAIL sb_clear_same_cycle got=%b exp=%b", if_a.SR2_busy, exp_b);
    end
    ld = 1'b0;
    tick();
    checks++;
    if (if_a.SR2_busy !== 1'b0 || if_a.SR2_out !== 16'h4444) begin
      failures++;
      $display("FAIL sb_cleared_r4 got=%b/%h exp=0/4444", if_a.SR2_busy, if_a.SR2_out);
    end
    sbset = 1'b1; sbdr = 3'd6; ld = 1'b1; dr = 3'd6; dbus = 16'h6666;
    tick();
    idle(); sr1 = 3'd6;
    tick();
    checks++;
    if (if_a.SR1_busy !== 1'b1 || if_a.SR1_out !== 16'h6666) begin
      failures++;
      $display("FAIL sb_set_wins_r6 got=%b/%h exp=1/6666", if_a.SR1_busy, if_a.SR1_out);
    end
    checks++;
    if (if_b.SR1_busy !== 1'b0 || if_b.SR1_out !== 16'h0) begin
      failures++;
      $display("FAIL n6_r6_unbacked got=%b/%h exp=0/0000", if_b.SR1_busy, if_b.SR1_out);
    end
  endtask

  task automatic test_bounds();
    for (int i = 0; i < 6; i++) begin
      ld = 1'b1; dr = 3'(i); dbus = 16'hA000 + 16'(i);
      tick();
    end
    ld = 1'b1; dr = 3'd7; dbus = 16'hFFFF; sbset = 1'b1; sbdr = 3'd7;
    tick();
    idle(); sr1 = 3'd7; sr2 = 3'd7;
    tick();
    checks++;
    if (if_b.SR1_out !== 16'h0 || if_b.SR1_busy !== 1'b0) begin
      failures++;
      $display("FAIL bounds_r7 got=%h/%b exp=0000/0", if_b.SR1_out, if_b.SR1_busy);
    end
    checks++;
    if (if_a.SR2_out !== 16'hFFFF || if_a.SR2_busy !== 1'b1) begin
      failures++;
      $display("FAIL n8_r7_backed got=%h/%b exp=FFFF/1", if_a.SR2_out, if_a.SR2_busy);
    end
    for (int i = 0; i < 6; i++) begin
      sr1 = 3'(i); sr2 = 3'(5 - i);
      tick();
      checks++;
      if (if_b.SR1_out !== 16'hA000 + 16'(i) || if_b.SR2_out !== 16'hA000 + 16'(5 - i) ||
          if_b.SR1_busy !== 1'b0) begin
        failures++;
        $display("FAIL bounds_unchanged idx=%0d got=%h/%h/%b exp=%h/%h/0", i,
                 if_b.SR1_out, if_b.SR2_out, if_b.SR1_busy,
                 16'hA000 + 16'(i), 16'hA000 + 16'(5 - i));
      end
    end
  endtask

  task automatic test_zero_reg();
    ld = 1'b1; dr = 3'd0; dbus = 16'hAAAA; sbset = 1'b1; sbdr = 3'd0;
    tick();
    idle(); sr1 = 3'd0; sr2 = 3'd1;
    tick();
    checks++;
    if (if_c.SR1_out !== 16'h0 || if_c.SR1_busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_r0 got=%h/%b exp=0000/0", if_c.SR1_out, if_c.SR1_busy);
    end
    checks++;
    if (if_c.SR2_out !== 16'hA001) begin
      failures++;
      $display("FAIL zero_r1_normal got=%h exp=A001", if_c.SR2_out);
    end
    checks++;
    if (if_a.SR1_out !== 16'hAAAA || if_a.SR1_busy !== 1'b1) begin
      failures++;
      $display("FAIL nonzero_r0 got=%h/%b exp=AAAA/1", if_a.SR1_out, if_a.SR1_busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_override();
    test_write_read();
    test_same_cycle_raw();
    test_scoreboard();
    test_bounds();
    test_zero_reg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
